// File: rtl/cuadrado_16.sv
// cuadrado_16: out_RR = in_Q*in_Q + in_R by 16-step shift-add; ports clk, rst, init, in_Q, in_R -> out_RR, out_BUSY, out_DONE
module cuadrado_16 #(
  parameter int N_BITS    = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [N_BITS-1:0]     in_Q,
  input  logic [N_BITS-1:0]     in_R,
  output logic [2*N_BITS-1:0]   out_RR,
  output logic                  out_BUSY,
  output logic                  out_DONE
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N_BITS-1:0] a_q, a_d, acc_q, acc_d, rr_q, rr_d, sum;
  logic [N_BITS-1:0] b_q, b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic done_q, done_d, busy_q, busy_d;
  assign sum = b_q[0] ? acc_q + a_q : acc_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    unique case (state_q)
      IDLE: if (init) begin
        a_d = {{N_BITS{1'b0}}, in_Q};
        b_d = in_Q;
        acc_d = {{N_BITS{1'b0}}, in_R};
        cnt_d = CNT_WIDTH'(N_BITS);
        state_d = ITER;
      end
      ITER: begin
        acc_d = sum;
        a_d = a_q << 1;
        b_d = b_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_WIDTH'(1)) begin
          rr_d = sum;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      rr_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
  assign out_RR = rr_q;
  assign out_BUSY = busy_q;
  assign out_DONE = done_q;
endmodule

// File: tb/tb_cuadrado_16.sv
// tb_cuadrado_16: random and directed stimulus for cuadrado_16 checked against a timeline model every cycle
module tb_cuadrado_16;
  localparam int N = 16;
  logic clk = 1'b0, rst = 1'b1, init = 1'b0;
  logic [15:0] in_Q = '0, in_R = '0;
  logic [31:0] out_RR;
  logic out_BUSY, out_DONE;
  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;
  bit m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_rr = '0, m_pend = '0;
  int m_t = 0;
  logic [31:0] res;
  int lat, q, x;
  always #5 clk = ~clk;
  cuadrado_16 dut (
    .clk(clk), .rst(rst), .init(init), .in_Q(in_Q), .in_R(in_R),
    .out_RR(out_RR), .out_BUSY(out_BUSY), .out_DONE(out_DONE)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int isqrt(input int v);
    int r = 0;
    for (int b = 7; b >= 0; b--)
      if ((r | (1 << b)) * (r | (1 << b)) <= v) r = r | (1 << b);
    return r;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_rr = '0;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (init) begin
        m_busy = 1'b1;
        m_t = 0;
        m_pend = 32'(in_Q) * 32'(in_Q) + 32'(in_R);
      end
    end else begin
      m_t++;
      m_done = m_t == N;
      if (m_t == N) m_rr = m_pend;
      if (m_t == N + 1) m_busy = 1'b0;
    end
  end
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("rr", out_RR, m_rr);
      chk("busy", 32'(out_BUSY), 32'(m_busy));
      chk("done", 32'(out_DONE), 32'(m_done));
    end
  end
  task automatic wait_done(output int l);
    l = 0;
    while (l < 40) begin
      @(posedge clk);
      #2;
      l++;
      if (out_DONE) break;
    end
  endtask
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output logic [31:0] r, output int l);
    @(negedge clk);
    in_Q = a;
    in_R = b;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    in_Q = 16'($urandom);
    in_R = 16'($urandom);
    wait_done(l);
    r = out_RR;
    @(posedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset_rr", out_RR, 32'h0);
    chk("reset_busy", 32'(out_BUSY), 32'h0);
    chk("reset_done", 32'(out_DONE), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd3, 16'd1, res, lat);
    chk("sq3", res, 32'h0000000A);
    chk("lat3", 32'(lat), 32'd16);
    run_op(16'hFFFF, 16'hFFFF, res, lat);
    chk("max", res, 32'hFFFF0000);
    chk("lat_max", 32'(lat), 32'd16);
    run_op(16'd0, 16'd0, res, lat);
    chk("zero", res, 32'h0);
    chk("lat_zero", 32'(lat), 32'd16);
    run_op(16'd31, 16'd39, res, lat);
    chk("rt1000", res, 32'd1000);
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 65535));
      q = isqrt(x);
      run_op(16'(q), 16'(x - q * q), res, lat);
      chk("roundtrip", res, 32'(x));
    end
    @(negedge clk);
    in_Q = 16'd5;
    in_R = 16'd2;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (5) @(negedge clk);
    in_Q = 16'd100;
    in_R = 16'd7;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_done(lat);
    chk("ignore_init", out_RR, 32'd27);
    @(posedge clk);
    @(negedge clk);
    in_Q = 16'd7;
    in_R = 16'd3;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_busy", 32'(out_BUSY), 32'h0);
    chk("abort_rr", out_RR, 32'h0);
    chk("abort_done", 32'(out_DONE), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'd12, 16'd5, res, lat);
    chk("after_abort", res, 32'd149);
    @(negedge clk);
    init = 1'b1;
    wait_done(lat);
    wait_done(lat);
    chk("gap1", 32'(lat), 32'd18);
    wait_done(lat);
    chk("gap2", 32'(lat), 32'd18);
    @(negedge clk);
    init = 1'b0;
    repeat (30) begin
      @(negedge clk);
      in_Q = 16'($urandom);
      in_R = 16'($urandom);
    end
    repeat (600) begin
      @(negedge clk);
      in_Q = 16'($urandom);
      in_R = 16'($urandom);
      init = $urandom_range(0, 3) == 0;
      rst = $urandom_range(0, 199) == 0;
    end
    @(negedge clk);
    rst = 1'b0;
    init = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
